add_pipe: RTL
=============

Name: add_pipe

Overview:
- Parametrised, pipelined two-operand adder/subtractor. Successor to the team's 4-bit combinational sum/overflow adder.
- Splits a WIDTH-bit add into CHUNK-bit carry-chained pipeline stages. Inputs and outputs use valid/ready handshakes.
- Supports unsigned and signed overflow detection, selected per transaction.
- Used as the arithmetic datapath element wherever an operand stream must be summed at one result per clock.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits added per pipeline stage. STAGES = WIDTH/CHUNK is derived, not a parameter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 computes a+b; 1 computes a-b.
- sgn  input  1  0 selects unsigned overflow rules; 1 selects two's-complement rules.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH (or saturated, see Optional Feature).
- overflow  output  1  overflow flag for this result.

Behaviour:
- Reset: rst is sampled at a rising edge of clk.
  - On reset, all stage valid bits clear and all pipeline data registers clear. out_valid=0, sum=0, overflow=0.
  - in_ready=0 in any cycle where rst=1.
  - In-flight beats are discarded, not completed.
- Transfer rules:
  - An input beat is accepted when in_valid && in_ready at a clock edge.
  - An output beat is consumed when out_valid && out_ready.
- Stall rule: stall = out_valid && !out_ready.
  - in_ready = !rst && !stall. This is combinational and creates no path from in_valid.
  - During stall, every stage register, including sum/overflow, holds its value.
- Latency and throughput:
  - A beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles of latency.
  - For STAGES=1 the result registers on the accept edge.
  - Sustained throughput is 1 beat/cycle when out_ready=1.
  - Order is preserved. No beat is dropped or duplicated.
- Arithmetic: the block computes a + (sub ? ~b : b) + sub.
  - Stage k adds bits [k*CHUNK +: CHUNK] plus the carry registered from stage k-1.
  - Higher operand slices and per-transaction control bits (sub, sgn) travel with the beat through delay registers.
  - Completed low slices are carried forward alongside.
- Overflow:
  - sgn=0, sub=0: overflow = carry-out of the MSB.
  - sgn=0, sub=1: overflow = borrow = !carry-out (a < b unsigned).
  - sgn=1, sub=0: overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - sgn=1, sub=1: overflow = (a[MSB]!=b[MSB]) && (sum[MSB]!=a[MSB]).
- Boundaries:
  - sgn/sub may change every beat. Each result uses the control bits captured with its own beat.
  - A bubble (in_valid=0) propagates as an invalid stage and produces no output beat.
  - If rst and in_valid are both high, the beat is not accepted.
  - If out_ready is low while out_valid is low, the pipeline continues to advance (bubbles are not stalls).
  - a=b=0 with sub=1 produces sum=0, overflow=0.

Optional Feature:
- Macro: ADD_PIPE_SAT_EN.
- Defined: when overflow=1, sum is clamped. overflow still reports 1.
  - sgn=0, sub=0: sum = all ones.
  - sgn=0, sub=1: sum = 0.
  - sgn=1: sum = most-positive if a[MSB]=0, otherwise most-negative.
  - The clamp is applied in the final stage and adds no latency.
- Undefined: sum always wraps modulo 2^WIDTH. No clamp logic is present.

Test Plan:
- WIDTH=8, CHUNK=4, sgn=0, sub=0, a=200, b=100, out_ready=1 -> 2 cycles later sum=44, overflow=1 (with SAT_EN: sum=255, overflow=1).
- WIDTH=8, CHUNK=4, sgn=1, sub=0, a=0x64, b=0x64 -> sum=0xC8, overflow=1 (SAT_EN: sum=0x7F). Then a=0x80, b=0xFF -> sum=0x7F, overflow=1 (SAT_EN: sum=0x80).
- sgn=0, sub=1, a=5, b=7 -> sum=0xFE, overflow=1 (SAT_EN: sum=0x00). sgn=1, sub=1, a=5, b=7 -> sum=0xFE, overflow=0.
- Stream 16 beats back-to-back while out_ready follows a pseudo-random pattern -> results emerge in order and match the model. in_ready=0 exactly in stall cycles. Held sum/overflow stay stable during stall.
- Assert rst for 1 cycle with 2 beats in flight -> no output beat for those 2 beats. out_valid=0, sum=0, overflow=0 the cycle after. A new beat after reset returns with the normal 2-cycle latency.
- WIDTH=4, CHUNK=2: sweep all 256 (a,b) pairs for each of the 4 (sub,sgn) combinations, continuous in_valid -> every {overflow,sum} matches the reference model. Repeat with WIDTH=4, CHUNK=4 (STAGES=1, latency 1).

Source files
------------

// File: rtl/add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : add_pipe
// Brief    : Pipelined WIDTH-bit adder/subtractor, CHUNK bits per stage, with
//            valid/ready handshake and unsigned/signed overflow detection.
//            Define ADD_PIPE_SAT_EN to saturate sum on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module add_pipe #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sgn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
);
   localparam int STAGES = WIDTH / CHUNK;

   logic stall;
   assign stall    = out_valid && !out_ready;
   assign in_ready = !rst && !stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * CHUNK;
      localparam int BW = WIDTH - LO;

      // w_x holds finished sum slices below LO and untouched A slices above.
      logic [WIDTH-1:0] w_x;
      logic [BW-1:0]    w_bh;
      logic             w_v;
      logic             w_cin;
      logic             w_sub;
      logic             w_sgn;
      logic             w_cout;
      logic [CHUNK-1:0] w_s;
      logic [WIDTH-1:0] w_res;
      logic [WIDTH-1:0] w_nxt;
      logic             r_v;
      logic [WIDTH-1:0] r_res;

      if (k == 0) begin : g_in
         assign w_x   = a;
         assign w_bh  = sub ? ~b : b;
         assign w_v   = in_valid && in_ready;
         assign w_cin = sub;
         assign w_sub = sub;
         assign w_sgn = sgn;
      end else begin : g_link
         assign w_x   = g_stage[k-1].r_res;
         assign w_bh  = g_stage[k-1].g_mid.r_bh;
         assign w_v   = g_stage[k-1].r_v;
         assign w_cin = g_stage[k-1].g_mid.r_c;
         assign w_sub = g_stage[k-1].g_mid.r_sub;
         assign w_sgn = g_stage[k-1].g_mid.r_sgn;
      end

      assign {w_cout, w_s} = {1'b0, w_x[LO +: CHUNK]} + {1'b0, w_bh[CHUNK-1:0]}
                           + {{CHUNK{1'b0}}, w_cin};

      always_comb begin
         w_res             = w_x;
         w_res[LO +: CHUNK] = w_s;
      end

      if (k < STAGES - 1) begin : g_mid
         logic [BW-CHUNK-1:0] r_bh;
         logic                r_c;
         logic                r_sub;
         logic                r_sgn;

         assign w_nxt = w_res;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_bh  <= '0;
               r_c   <= 1'b0;
               r_sub <= 1'b0;
               r_sgn <= 1'b0;
            end else if (!stall) begin
               r_bh  <= w_bh[BW-1:CHUNK];
               r_c   <= w_cout;
               r_sub <= w_sub;
               r_sgn <= w_sgn;
            end
         end
      end else begin : g_out
         logic w_ovf;
         logic r_ovf;

         // w_bh holds the already-inverted B for subtracts, so one signed test serves both.
         assign w_ovf = w_sgn ? ((w_x[WIDTH-1] == w_bh[CHUNK-1]) &&
                                 (w_res[WIDTH-1] != w_x[WIDTH-1]))
                              : (w_cout ^ w_sub);

`ifdef ADD_PIPE_SAT_EN
         always_comb begin
            w_nxt = w_res;
            if (w_ovf) begin
               if (!w_sgn)
                  w_nxt = w_sub ? '0 : '1;
               else if (w_x[WIDTH-1])
                  w_nxt = {1'b1, {(WIDTH-1){1'b0}}};
               else
                  w_nxt = {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
`else
         assign w_nxt = w_res;
`endif

         always_ff @(posedge clk) begin
            if (rst)
               r_ovf <= 1'b0;
            else if (!stall)
               r_ovf <= w_ovf;
         end

         assign out_valid = r_v;
         assign sum       = r_res;
         assign overflow  = r_ovf;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_v   <= 1'b0;
            r_res <= '0;
         end else if (!stall) begin
            r_v   <= w_v;
            r_res <= w_nxt;
         end
      end
   end

endmodule
`default_nettype wire
